uart_tx_sched: RTL
==================

# uart_tx_sched

Frame scheduler between the Ethernet-RX byte FIFO, a status-byte source and the single UART transmitter. It sits in the 100 MHz UART clock domain, on the FIFO read side. It arbitrates round-robin between payload data and status bytes, wraps each grant in a header-tagged frame, and paces bytes to the UART's start/busy handshake.

## Interface
- BURST_LEN, 16: max payload bytes per data frame (1..255)
- HDR_DATA, 8'hA5: header byte of a data frame
- HDR_STAT, 8'h5A: header byte of a status frame
- clk  in  1  UART-domain clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- data_empty  in  1  FIFO empty flag
- data_rd_en  out  1  FIFO read strobe; standard-mode FIFO, dout valid the cycle after the strobe
- data_dout  in  8  FIFO read data
- stat_valid  in  1  status byte offered
- stat_data  in  8  status byte
- stat_ready  out  1  one-cycle accept; the transfer occurs when stat_valid and stat_ready are both high
- tx_start  out  1  one-cycle pulse that launches a UART byte
- tx_data  out  8  byte to send; held stable from tx_start until the next tx_start
- tx_busy  in  1  UART busy; high from the cycle after tx_start until the byte completes
- sched_busy  out  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset values: data_rd_en=0, stat_ready=0, tx_start=0, tx_data=8'h00, sched_busy=0.
- Internal registers: state, last_grant (reset value STAT, so data wins first), cnt (8 bits), cks (8 bits), cks_sent.
- States: IDLE, WAIT, RD, LOAD.
- IDLE, arbitration:
  - Pending sources are data (data_empty==0) and status (stat_valid==1).
  - If both are pending, grant the source that is not last_grant. Otherwise grant the single pending source.
  - Data grant: tx_start<=1, tx_data<=HDR_DATA, cnt<=0, cks<=HDR_DATA, last_grant<=DATA, state->WAIT.
  - Status grant: stat_ready<=1 for one cycle, stat_data is latched, tx_start<=1, tx_data<=HDR_STAT, cks<=HDR_STAT, last_grant<=STAT, state->WAIT.
- WAIT: tx_start<=0. The state ignores tx_busy in its first cycle and advances only when tx_busy==0.
  - Data frame with cnt<BURST_LEN and data_empty==0: data_rd_en<=1, state->RD.
  - Status frame with the status byte not yet sent: tx_start<=1, tx_data<=latched byte, cks^=byte, state stays WAIT.
  - Frame payload done: with the macro, send the checksum if not yet sent (see Configuration); otherwise state->IDLE.
- RD: data_rd_en<=0, state->LOAD.
- LOAD: tx_data<=data_dout, tx_start<=1, cnt<=cnt+1, cks<=cks^data_dout, state->WAIT.
- A data frame ends when cnt==BURST_LEN or data_empty==1 at the WAIT decision. Frames are never interrupted.
- Boundary conditions:
  - The FIFO empties mid-burst: the frame is short and closes normally.
  - stat_valid drops before acceptance: no status frame is started.
  - Arithmetic: cnt never exceeds BURST_LEN. cks is a plain 8-bit XOR with no carry.
  - rst mid-frame: immediate return to reset values. A byte that was fetched but not sent is dropped; the FIFO is not rewound.

## Timing
- IDLE grant to the header tx_start: 1 cycle.
- Between data bytes, measured from the cycle where tx_busy is seen low to the next tx_start: 3 cycles (rd_en, RD, LOAD).
- Status byte after the header, and checksum after the last byte: tx_start 1 cycle after tx_busy is seen low.
- IDLE re-arbitrates in the cycle after frame completion.
- tx_start is never asserted while tx_busy==1.
- data_rd_en is never asserted while data_empty==1.

## Configuration
- UART_SCHED_CKSUM_EN defined:
  - At the end of each frame, WAIT issues tx_start with tx_data=cks and sets cks_sent; the next WAIT exit goes to IDLE.
  - cks is the XOR of the header and all payload bytes of that frame.
- Undefined: the frame ends right after the last payload byte. The cks/cks_sent logic is absent.

## Structure
- Package uart_sched_pkg holds:
  - the state enum (IDLE, WAIT, RD, LOAD);
  - grant encoding (DATA, STAT);
  - default header constants.
- No sub-module. The design is one FSM plus cnt/cks registers; the arbiter is two lines of the IDLE logic.

## Test plan
- Reset, FIFO preloaded with 3 bytes 11,22,33, macro off -> UART sees A5,11,22,33, then sched_busy=0. There are exactly 3 data_rd_en pulses.
- BURST_LEN=4, 6 bytes 01..06 -> frame A5,01..04, then frame A5,05,06. IDLE re-arbitrates between the frames.
- Data and status pending together from reset (stat_data=C3), 2 data bytes -> A5,d0,d1 first, then 5A,C3. stat_ready pulses once, exactly when the 5A header issues.
- Macro on, FIFO bytes 0F,F0 -> A5,0F,F0,5A. Checksum = A5^0F^F0 = 5A.
- tx_busy held high 50 cycles per byte -> no tx_start while busy; gap from busy-low to next data tx_start = 3 cycles.
- rst asserted in LOAD mid-burst -> all outputs go to reset values the same cycle. After release, the next frame starts with HDR_DATA from the remaining FIFO contents.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART frame scheduler: FSM state codes, grant encoding
// and default header bytes.
package uart_sched_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] ST_RD   = 2'd2;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd3;

    localparam logic GNT_DATA = 1'b0;
    localparam logic GNT_STAT = 1'b1;

    localparam logic [BYTE_W-1:0] HDR_DATA_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR_STAT_DEF = 8'h5A;

endpackage

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler feeding one UART transmitter from a byte FIFO and a status source.
// Define UART_SCHED_CKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned        BURST_LEN = 16,
    parameter logic [BYTE_W-1:0]  HDR_DATA  = HDR_DATA_DEF,
    parameter logic [BYTE_W-1:0]  HDR_STAT  = HDR_STAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_empty,
    output logic              data_rd_en,
    input  logic [BYTE_W-1:0] data_dout,
    input  logic              stat_valid,
    input  logic [BYTE_W-1:0] stat_data,
    output logic              stat_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              sched_busy
);

    localparam logic [BYTE_W-1:0] BURST_MAX = BYTE_W'(BURST_LEN);

    logic [STATE_W-1:0] state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               frame_stat_q, frame_stat_d;
    logic               stat_sent_q, stat_sent_d;
    logic               wait_first_q, wait_first_d;
    logic [BYTE_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0]  stat_byte_q, stat_byte_d;

    logic               data_rd_en_d;
    logic               stat_ready_d;
    logic               tx_start_d;
    logic [BYTE_W-1:0]  tx_data_d;
    logic               sched_busy_d;
    logic               grant_stat;

`ifdef UART_SCHED_CKSUM_EN
    logic [BYTE_W-1:0]  cks_q, cks_d;
    logic               cks_sent_q, cks_sent_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cks_q      <= '0;
            cks_sent_q <= 1'b0;
        end else begin
            cks_q      <= cks_d;
            cks_sent_q <= cks_sent_d;
        end
    end
`endif

    // State, bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_STAT;
            frame_stat_q <= 1'b0;
            stat_sent_q  <= 1'b0;
            wait_first_q <= 1'b0;
            cnt_q        <= '0;
            stat_byte_q  <= '0;
            data_rd_en   <= 1'b0;
            stat_ready   <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            sched_busy   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            frame_stat_q <= frame_stat_d;
            stat_sent_q  <= stat_sent_d;
            wait_first_q <= wait_first_d;
            cnt_q        <= cnt_d;
            stat_byte_q  <= stat_byte_d;
            data_rd_en   <= data_rd_en_d;
            stat_ready   <= stat_ready_d;
            tx_start     <= tx_start_d;
            tx_data      <= tx_data_d;
            sched_busy   <= sched_busy_d;
        end
    end

    // Status wins only when it is the sole requester or data was granted last
    assign grant_stat = stat_valid && (data_empty || (last_grant_q == GNT_DATA));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        frame_stat_d = frame_stat_q;
        stat_sent_d  = stat_sent_q;
        wait_first_d = wait_first_q;
        cnt_d        = cnt_q;
        stat_byte_d  = stat_byte_q;
        data_rd_en_d = 1'b0;
        stat_ready_d = 1'b0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data;
`ifdef UART_SCHED_CKSUM_EN
        cks_d        = cks_q;
        cks_sent_d   = cks_sent_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!data_empty || stat_valid) begin
                    tx_start_d   = 1'b1;
                    wait_first_d = 1'b1;
                    stat_sent_d  = 1'b0;
                    state_d      = ST_WAIT;
`ifdef UART_SCHED_CKSUM_EN
                    cks_sent_d   = 1'b0;
`endif
                    if (grant_stat) begin
                        stat_ready_d = 1'b1;
                        stat_byte_d  = stat_data;
                        tx_data_d    = HDR_STAT;
                        last_grant_d = GNT_STAT;
                        frame_stat_d = 1'b1;
`ifdef UART_SCHED_CKSUM_EN
                        cks_d        = HDR_STAT;
`endif
                    end else begin
                        tx_data_d    = HDR_DATA;
                        cnt_d        = '0;
                        last_grant_d = GNT_DATA;
                        frame_stat_d = 1'b0;
`ifdef UART_SCHED_CKSUM_EN
                        cks_d        = HDR_DATA;
`endif
                    end
                end
            end

            // The UART raises busy only in the cycle after tx_start, so the first WAIT cycle is skipped
            ST_WAIT: begin
                wait_first_d = 1'b0;
                if (!wait_first_q && !tx_busy) begin
                    if (!frame_stat_q && (cnt_q < BURST_MAX) && !data_empty) begin
                        data_rd_en_d = 1'b1;
                        state_d      = ST_RD;
                    end else if (frame_stat_q && !stat_sent_q) begin
                        tx_start_d   = 1'b1;
                        tx_data_d    = stat_byte_q;
                        stat_sent_d  = 1'b1;
                        wait_first_d = 1'b1;
`ifdef UART_SCHED_CKSUM_EN
                        cks_d        = cks_q ^ stat_byte_q;
`endif
                    end else begin
`ifdef UART_SCHED_CKSUM_EN
                        if (!cks_sent_q) begin
                            tx_start_d   = 1'b1;
                            tx_data_d    = cks_q;
                            cks_sent_d   = 1'b1;
                            wait_first_d = 1'b1;
                        end else begin
                            state_d      = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end

            ST_RD: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                tx_data_d    = data_dout;
                tx_start_d   = 1'b1;
                cnt_d        = cnt_q + 8'd1;
                wait_first_d = 1'b1;
                state_d      = ST_WAIT;
`ifdef UART_SCHED_CKSUM_EN
                cks_d        = cks_q ^ data_dout;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sched_busy_d = (state_d != ST_IDLE);
    end

endmodule
